// File: rtl/diff_freq_serial_out_core.sv
// Byte-command decoder feeding OUTPUT_NUM serial pattern channels; each bit is held for a
// slow or fast period selected by a shared frequency pattern.
module diff_freq_serial_out_core #(
    parameter int unsigned DATA_BIT    = 32,
    parameter int unsigned DATA_NUM    = 4,
    parameter int unsigned OUTPUT_NUM  = 16,
    parameter int unsigned SLOW_PERIOD = 20,
    parameter int unsigned FAST_PERIOD = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            data_i,
    input  logic                  rx_done_tick_i,
    output logic [OUTPUT_NUM-1:0] serial_out_o
);

    localparam int unsigned BcW  = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int unsigned ChW  = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
    localparam int unsigned IdxW = $clog2(DATA_BIT);
    localparam int unsigned NbW  = $clog2(DATA_BIT + 1);

    localparam logic [7:0] CmdData   = 8'h01;
    localparam logic [7:0] CmdCtrl   = 8'h02;
    localparam logic [7:0] CmdFreq   = 8'h03;
    localparam logic [7:0] CmdPeriod = 8'h04;
    localparam logic [7:0] CmdRepeat = 8'h05;
    localparam logic [7:0] CmdGlobal = 8'h06;

    typedef enum logic [3:0] {
        StIdle, StDataCh, StDataAmt, StDataByte, StCtrlCh, StCtrlVal, StFreqAmt, StFreqByte,
        StPerSlow, StPerFast, StRepCh, StRepTimes, StGlobal
    } dec_state_e;

    dec_state_e          state_q, state_d;
    logic [7:0]          ch_q, ch_d;
    logic [7:0]          amt_q, amt_d;
    logic [BcW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DATA_BIT-9:0] buf_q, buf_d;
    logic [7:0]          slow_tmp_q, slow_tmp_d;

    logic wr_data, wr_ctrl, wr_freq, wr_period, wr_rep, wr_glob;
    logic [DATA_BIT-1:0] word_in;
    logic [DATA_BIT-1:0] freq_mask;
    logic [ChW-1:0]      ch_idx;
    logic                ch_ok;

    logic [DATA_BIT-1:0] pattern_q [OUTPUT_NUM];
    logic [7:0]          amount_q  [OUTPUT_NUM];
    logic [3:0]          ctrl_q    [OUTPUT_NUM];
    logic [7:0]          times_q   [OUTPUT_NUM];
    logic [7:0]          slow_q, fast_q;
    logic [DATA_BIT-1:0] freq_q;
    logic [7:0]          slow_eff, fast_eff;

    // Multibyte values arrive LSB first, so each new byte enters at the top.
    assign word_in  = {data_i, buf_q};
    assign ch_idx   = ch_q[ChW-1:0];
    assign ch_ok    = (32'(ch_q) < OUTPUT_NUM);
    assign slow_eff = (slow_q == 8'd0) ? 8'd1 : slow_q;
    assign fast_eff = (fast_q == 8'd0) ? 8'd1 : fast_q;

    function automatic logic [NbW-1:0] amount_bits(input logic [7:0] amt);
        logic [10:0] nbits;
        nbits = {amt, 3'b000};
        if (nbits >= 11'(DATA_BIT)) return NbW'(DATA_BIT);
        return NbW'(nbits);
    endfunction

    always_comb begin
        for (int b = 0; b < DATA_BIT; b++) begin
            freq_mask[b] = (11'(b) < {amt_q, 3'b000});
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        amt_d      = amt_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        slow_tmp_d = slow_tmp_q;
        wr_data    = 1'b0;
        wr_ctrl    = 1'b0;
        wr_freq    = 1'b0;
        wr_period  = 1'b0;
        wr_rep     = 1'b0;
        wr_glob    = 1'b0;
        if (rx_done_tick_i) begin
            unique case (state_q)
                StIdle: begin
                    case (data_i)
                        CmdData:   state_d = StDataCh;
                        CmdCtrl:   state_d = StCtrlCh;
                        CmdFreq:   state_d = StFreqAmt;
                        CmdPeriod: state_d = StPerSlow;
                        CmdRepeat: state_d = StRepCh;
                        CmdGlobal: state_d = StGlobal;
                        default:   state_d = StIdle;
                    endcase
                end
                StDataCh: begin
                    ch_d    = data_i;
                    state_d = StDataAmt;
                end
                StDataAmt, StFreqAmt: begin
                    amt_d      = data_i;
                    byte_cnt_d = '0;
                    state_d    = (state_q == StDataAmt) ? StDataByte : StFreqByte;
                end
                StDataByte, StFreqByte: begin
                    buf_d = word_in[DATA_BIT-1:8];
                    if (byte_cnt_q == BcW'(DATA_NUM - 1)) begin
                        wr_data = (state_q == StDataByte);
                        wr_freq = (state_q == StFreqByte);
                        state_d = StIdle;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                StCtrlCh: begin
                    ch_d    = data_i;
                    state_d = StCtrlVal;
                end
                StCtrlVal: begin
                    wr_ctrl = 1'b1;
                    state_d = StIdle;
                end
                StPerSlow: begin
                    slow_tmp_d = data_i;
                    state_d    = StPerFast;
                end
                StPerFast: begin
                    wr_period = 1'b1;
                    state_d   = StIdle;
                end
                StRepCh: begin
                    ch_d    = data_i;
                    state_d = StRepTimes;
                end
                StRepTimes: begin
                    wr_rep  = 1'b1;
                    state_d = StIdle;
                end
                StGlobal: begin
                    wr_glob = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            amt_q      <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            slow_tmp_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            amt_q      <= amt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            slow_tmp_q <= slow_tmp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slow_q <= 8'(SLOW_PERIOD);
            fast_q <= 8'(FAST_PERIOD);
            freq_q <= '0;
            for (int c = 0; c < OUTPUT_NUM; c++) begin
                pattern_q[c] <= '0;
                amount_q[c]  <= '0;
                ctrl_q[c]    <= '0;
                times_q[c]   <= 8'd1;
            end
        end else begin
            if (wr_period) begin
                slow_q <= slow_tmp_q;
                fast_q <= data_i;
            end
            if (wr_freq) freq_q <= word_in & freq_mask;
            if (wr_data && ch_ok) begin
                pattern_q[ch_idx] <= word_in;
                amount_q[ch_idx]  <= amt_q;
            end
            if (wr_ctrl && ch_ok) ctrl_q[ch_idx] <= data_i[3:0];
            if (wr_rep && ch_ok) times_q[ch_idx] <= data_i;
        end
    end

    for (genvar g = 0; g < OUTPUT_NUM; g++) begin : g_ch
        logic                run_q, run_d;
        logic [DATA_BIT-1:0] pat_q, pat_d;
        logic [NbW-1:0]      nb_q, nb_d;
        logic [1:0]          mode_q, mode_d;
        logic [7:0]          pass_q, pass_d;
        logic [IdxW-1:0]     idx_q, idx_d;
        logic [7:0]          cnt_q, cnt_d;
        logic [7:0]          per_q, per_d;
        logic                out_q, out_d;
        logic [NbW-1:0]      start_nb;
        logic [7:0]          per_now, cur_per;

        always_comb begin
            run_d    = run_q;
            pat_d    = pat_q;
            nb_d     = nb_q;
            mode_d   = mode_q;
            pass_d   = pass_q;
            idx_d    = idx_q;
            cnt_d    = cnt_q;
            per_d    = per_q;
            start_nb = amount_bits(amount_q[g]);
            // Period is taken live on the first cycle of a bit, then held for the rest of it.
            per_now  = freq_q[idx_q] ? fast_eff : slow_eff;
            cur_per  = (cnt_q == 8'd0) ? per_now : per_q;
            out_d    = run_q ? pat_q[idx_q] : ctrl_q[g][3];

            if (run_q) begin
                if (cnt_q == 8'd0) per_d = per_now;
                if (cnt_q == cur_per - 8'd1) begin
                    cnt_d = 8'd0;
                    if (NbW'(idx_q) + NbW'(1) == nb_q) begin
                        idx_d = '0;
                        if (mode_q == 2'b01) begin
                            run_d = 1'b1;
                        end else if (mode_q == 2'b10 && pass_q > 8'd1) begin
                            pass_d = pass_q - 8'd1;
                        end else begin
                            run_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            if (wr_glob) begin
                if (!data_i[0]) begin
                    run_d = 1'b0;
                end else if (ctrl_q[g][0]) begin
                    pat_d  = pattern_q[g];
                    nb_d   = start_nb;
                    mode_d = ctrl_q[g][2:1];
                    pass_d = (times_q[g] == 8'd0) ? 8'd1 : times_q[g];
                    idx_d  = '0;
                    cnt_d  = 8'd0;
                    run_d  = (start_nb != '0);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                run_q  <= 1'b0;
                pat_q  <= '0;
                nb_q   <= '0;
                mode_q <= '0;
                pass_q <= '0;
                idx_q  <= '0;
                cnt_q  <= '0;
                per_q  <= '0;
                out_q  <= 1'b0;
            end else begin
                run_q  <= run_d;
                pat_q  <= pat_d;
                nb_q   <= nb_d;
                mode_q <= mode_d;
                pass_q <= pass_d;
                idx_q  <= idx_d;
                cnt_q  <= cnt_d;
                per_q  <= per_d;
                out_q  <= out_d;
            end
        end

        assign serial_out_o[g] = out_q;
    end

endmodule

// File: tb/tb_diff_freq_serial_out_core.sv
// Bench for diff_freq_serial_out_core: a packet-level model predicts every output cycle into a
// queue that is drained against the DUT, plus directed timing checks.
module tb_diff_freq_serial_out_core;

    localparam int NCH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [7:0]  data;
    logic [15:0] serial_out;

    always #5 clk = ~clk;

    diff_freq_serial_out_core dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_i         (data),
        .rx_done_tick_i (tick),
        .serial_out_o   (serial_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model configuration and per-channel run state
    logic [31:0] m_pat   [NCH];
    logic [7:0]  m_amt   [NCH];
    logic [3:0]  m_ctrl  [NCH];
    logic [7:0]  m_times [NCH];
    logic [7:0]  m_slow, m_fast;
    logic [31:0] m_freq;
    bit          m_run   [NCH];
    logic [31:0] r_pat   [NCH];
    int          r_nb    [NCH];
    logic [1:0]  r_mode  [NCH];
    int          r_pass  [NCH];
    int          r_pos   [NCH];
    int          r_left  [NCH];
    logic [7:0]  pkt     [$];
    logic [15:0] exp_q   [$];
    logic [15:0] m_e;
    logic [15:0] sb_exp;

    function automatic int pkt_len(input logic [7:0] cmd);
        case (cmd)
            8'h01:   return 7;
            8'h02:   return 3;
            8'h03:   return 6;
            8'h04:   return 3;
            8'h05:   return 3;
            8'h06:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int per_of(input logic fbit);
        int p;
        p = fbit ? int'(m_fast) : int'(m_slow);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pat[c] = '0; m_amt[c] = '0; m_ctrl[c] = '0; m_times[c] = 8'd1; m_run[c] = 1'b0;
        end
        m_slow = 8'd20;
        m_fast = 8'd5;
        m_freq = '0;
        pkt.delete();
    endtask

    task automatic model_apply();
        int ch;
        int a;
        logic [31:0] v;
        ch = int'(pkt[1]);
        v  = {pkt[pkt.size()-1], pkt[pkt.size()-2], pkt[pkt.size()-3], pkt[pkt.size()-4]};
        case (pkt[0])
            8'h01: if (ch < NCH) begin m_pat[ch] = v; m_amt[ch] = pkt[2]; end
            8'h02: if (ch < NCH) m_ctrl[ch] = pkt[2][3:0];
            8'h03: begin
                a = int'(pkt[1]);
                for (int b = 0; b < 32; b++) if (b >= 8 * a) v[b] = 1'b0;
                m_freq = v;
            end
            8'h04: begin m_slow = pkt[1]; m_fast = pkt[2]; end
            8'h05: if (ch < NCH) m_times[ch] = pkt[2];
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    if (!pkt[1][0]) begin
                        m_run[c] = 1'b0;
                    end else if (m_ctrl[c][0]) begin
                        a         = int'(m_amt[c]);
                        r_nb[c]   = ((a > 4) ? 4 : a) * 8;
                        r_pat[c]  = m_pat[c];
                        r_mode[c] = m_ctrl[c][2:1];
                        r_pass[c] = (m_times[c] == 0) ? 1 : int'(m_times[c]);
                        r_pos[c]  = 0;
                        r_left[c] = 0;
                        m_run[c]  = (r_nb[c] != 0);
                    end
                end
            end
        endcase
    endtask

    task automatic model_channels();
        for (int c = 0; c < NCH; c++) begin
            if (m_run[c]) begin
                if (r_left[c] == 0) r_left[c] = per_of(m_freq[r_pos[c]]);
                r_left[c]--;
                if (r_left[c] == 0) begin
                    r_pos[c]++;
                    if (r_pos[c] == r_nb[c]) begin
                        r_pos[c] = 0;
                        if (r_mode[c] == 2'b01) m_run[c] = 1'b1;
                        else if (r_mode[c] == 2'b10 && r_pass[c] > 1) r_pass[c]--;
                        else m_run[c] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Predict the output registered at this edge, then advance the model with this cycle's input.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) m_e[c] = m_run[c] ? r_pat[c][r_pos[c]] : m_ctrl[c][3];
        if (!rst_n) begin
            exp_q.push_back(16'h0000);
            model_reset();
        end else begin
            exp_q.push_back(m_e);
            model_channels();
            if (tick) begin
                pkt.push_back(data);
                if (pkt_len(pkt[0]) == 0) pkt.delete();
                else if (pkt.size() == pkt_len(pkt[0])) begin
                    model_apply();
                    pkt.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            check_eq("sb", {16'h0, serial_out}, {16'h0, sb_exp});
        end
    end

    // Called on a falling edge; leaves the byte valid for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        data = b;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic send_j(input logic [7:0] b);
        send_byte(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_j(w[8*i +: 8]);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rnd;
    logic [3:0]  cb;
    int          per;

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        data  = 8'h00;
        gap(3);
        check_eq("reset", {16'h0, serial_out}, 32'h0);
        rst_n = 1'b1;
        gap(2);

        // Idle level from CTRL reaches the pin two cycles after the final tick
        send_byte(8'h02); send_byte(8'd13); send_byte(8'h08);
        check_eq("ctrl_t1", {31'h0, serial_out[13]}, 32'h0);
        gap(1);
        check_eq("ctrl_t2", {31'h0, serial_out[13]}, 32'h1);
        gap(2);

        // One-shot timing, back-to-back bytes
        send_byte(8'h04); send_byte(8'd20); send_byte(8'd5);
        send_byte(8'h03); send_byte(8'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        send_byte(8'h01); send_byte(8'd0); send_byte(8'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        send_byte(8'h02); send_byte(8'd0); send_byte(8'h01);
        send_byte(8'h06); send_byte(8'h01);
        gap(1);
        for (int i = 0; i < 8; i++) begin
            per = (i % 2 == 0) ? 5 : 20;
            for (int k = 0; k < per; k++) begin
                check_eq("oneshot", {31'h0, serial_out[0]}, {31'h0, (i % 2 == 0)});
                gap(1);
            end
        end
        check_eq("oneshot_end", {31'h0, serial_out[0]}, 32'h0);
        gap(5);

        // Repeat mode: 3 passes of 16 bits, 8 fast (2) + 8 slow (4) clocks each
        send_j(8'h04); send_j(8'd4); send_j(8'd2);
        send_j(8'h05); send_j(8'd1); send_j(8'd3);
        send_j(8'h01); send_j(8'd1); send_j(8'd2); send_word(32'hF00F_C3A5);
        send_j(8'h02); send_j(8'd1); send_j(8'h05);
        gap(1);
        send_byte(8'h06); send_byte(8'h01);
        gap(144);
        check_eq("rep_last", {31'h0, serial_out[1]}, 32'h1);
        gap(1);
        check_eq("rep_idle", {31'h0, serial_out[1]}, 32'h0);
        gap(5);

        // Continuous channel stopped by GLOBAL 0
        rnd = $urandom();
        send_j(8'h01); send_j(8'd3); send_j(8'd4); send_word(rnd);
        send_j(8'h02); send_j(8'd3); send_j(8'h0B);
        send_byte(8'h06); send_byte(8'h01);
        gap(300);
        send_byte(8'h06); send_byte(8'h00);
        gap(1);
        check_eq("stop_idle", {31'h0, serial_out[3]}, 32'h1);
        check_eq("stop_all", {16'h0, serial_out}, 32'h2008);
        gap(3);

        // Filtering: out-of-range channels, unknown byte, disabled channel
        send_j(8'h01); send_j(8'd20); send_j(8'd4); send_word(32'hFFFF_FFFF);
        send_j(8'h7F);
        send_j(8'h02); send_j(8'd16); send_j(8'h0F);
        send_j(8'h05); send_j(8'd99); send_j(8'd7);
        send_j(8'h01); send_j(8'd2); send_j(8'd4); send_word(32'h0000_0000);
        send_j(8'h02); send_j(8'd2); send_j(8'h08);
        send_byte(8'h06); send_byte(8'h01);
        for (int k = 0; k < 20; k++) begin
            check_eq("dis_idle", {31'h0, serial_out[2]}, 32'h1);
            gap(1);
        end
        send_byte(8'h06); send_byte(8'h00);
        gap(3);

        // Zero periods, amount 0, amount above 4, times 0
        send_j(8'h04); send_j(8'd0); send_j(8'd0);
        send_j(8'h01); send_j(8'd4); send_j(8'd0); send_word(32'hFFFF_FFFF);
        send_j(8'h02); send_j(8'd4); send_j(8'h09);
        send_j(8'h05); send_j(8'd5); send_j(8'd0);
        send_j(8'h01); send_j(8'd5); send_j(8'd9); send_word($urandom());
        send_j(8'h02); send_j(8'd5); send_j(8'h05);
        send_byte(8'h06); send_byte(8'h01);
        gap(1);
        check_eq("amt0_idle", {31'h0, serial_out[4]}, 32'h1);
        gap(60);
        send_byte(8'h06); send_byte(8'h00);
        gap(3);

        // Full 16-channel configuration with jittered byte spacing
        send_j(8'h04); send_j(8'd3); send_j(8'd1);
        send_j(8'h03); send_j(8'd3); send_word($urandom());
        for (int c = 0; c < NCH; c++) begin
            send_j(8'h01); send_j(8'(c)); send_j(8'((c % 4) + 1)); send_word($urandom());
            send_j(8'h05); send_j(8'(c)); send_j(8'(2 + (c % 2)));
            cb = {(c >= 13), 3'b001};
            if (c == 1 || c == 3 || c == 8 || c == 14 || c == 15) cb[2:1] = 2'b10;
            if (c == 7) cb[2:1] = 2'b11;
            send_j(8'h02); send_j(8'(c)); send_j({4'h0, cb});
        end
        send_byte(8'h06); send_byte(8'h01);
        gap(40);
        send_j(8'h04); send_j(8'd2); send_j(8'd3);
        gap(40);
        send_j(8'h03); send_j(8'd4); send_word($urandom());
        gap(30);
        send_byte(8'h06); send_byte(8'h01);
        gap(450);
        check_eq("full_done", {16'h0, serial_out}, 32'hE000);
        send_byte(8'h06); send_byte(8'h00);
        gap(3);

        // Reset in the middle of a packet
        send_byte(8'h01); send_byte(8'd5);
        rst_n = 1'b0;
        gap(2);
        rst_n = 1'b1;
        check_eq("rst_mid", {16'h0, serial_out}, 32'h0);
        send_byte(8'h06); send_byte(8'h01);
        gap(10);
        check_eq("post_rst", {16'h0, serial_out}, 32'h0);
        gap(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
